// File: rtl/bus_mux_stom_link.sv
// Slave-to-master return path of the serial bus interconnect.
// Holds one latched master<->slave link and drives the selected slave's serial line
// back to the selected master through one register stage. An idle-line watchdog
// tears the link down when the connected slave stays at the idle level too long.
// The close request is named release_req because `release` is a reserved word.
module bus_mux_stom_link #(
    parameter int unsigned NO_MASTERS = 2,
    parameter int unsigned NO_SLAVES  = 3,
    parameter int unsigned S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int unsigned M_ID_WIDTH = $clog2(NO_MASTERS),
    parameter logic        IDLE_LEVEL = 1'b1,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TO_WIDTH   = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M_ID_WIDTH-1:0] master_sel,
    input  logic [S_ID_WIDTH-1:0] slave_sel,
    input  logic                  connect,
    input  logic                  release_req,
    input  logic [NO_SLAVES-1:0]  slave,
    output logic [NO_MASTERS-1:0] master,
    output logic                  busy,
    output logic                  timeout,
    output logic                  err
);

    typedef enum logic [0:0] {StIdle, StConnected} state_e;

    state_e                  state_q, state_d;
    logic [M_ID_WIDTH-1:0]   m_id_q, m_id_d;
    logic [S_ID_WIDTH-1:0]   s_id_q, s_id_d;
    logic [TO_WIDTH-1:0]     cnt_q, cnt_d;
    logic [NO_MASTERS-1:0]   master_q, master_d;
    logic                    busy_q, busy_d;
    logic                    timeout_q, timeout_d;
    logic                    err_q, err_d;

    logic                    sel_valid;
    logic                    sel_line;
    logic                    line_idle;
    logic                    wd_expire;

    // Request decode: id range check and the line of the latched slave
    always_comb begin
        sel_valid = (32'(master_sel) < NO_MASTERS) && (slave_sel != '0) &&
                    (32'(slave_sel) <= NO_SLAVES);
        sel_line  = IDLE_LEVEL;
        for (int unsigned k = 0; k < NO_SLAVES; k++) begin
            if (s_id_q == S_ID_WIDTH'(k + 1)) begin
                sel_line = slave[k];
            end
        end
        line_idle = (sel_line == IDLE_LEVEL);
        // Expire on the idle cycle that would make the count reach TIMEOUT
        wd_expire = line_idle && (cnt_q == TO_WIDTH'(TIMEOUT - 1));
    end

    // State and latched-link registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            m_id_q  <= '0;
            s_id_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_id_q  <= m_id_d;
            s_id_q  <= s_id_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: link open/close, watchdog counting
    always_comb begin
        state_d = state_q;
        m_id_d  = m_id_q;
        s_id_d  = s_id_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (connect && sel_valid) begin
                    state_d = StConnected;
                    m_id_d  = master_sel;
                    s_id_d  = slave_sel;
                end
            end
            StConnected: begin
                // Release has priority over the watchdog
                if (release_req || wd_expire) begin
                    state_d = StIdle;
                end
                if (!line_idle) begin
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: registered datapath, status and single-cycle pulses
    always_comb begin
        busy_d    = (state_d == StConnected);
        err_d     = connect && (((state_q == StIdle) && !sel_valid) ||
                                ((state_q == StConnected) && !release_req));
        timeout_d = (state_q == StConnected) && !release_req && wd_expire;
        master_d  = {NO_MASTERS{IDLE_LEVEL}};
        // Data only flows once the ids are latched, so the first cycle after connect is idle
        for (int unsigned i = 0; i < NO_MASTERS; i++) begin
            if ((state_q == StConnected) && (state_d == StConnected) &&
                (m_id_q == M_ID_WIDTH'(i))) begin
                master_d[i] = sel_line;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            master_q  <= {NO_MASTERS{IDLE_LEVEL}};
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            master_q  <= master_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign master  = master_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bus_mux_stom_link.sv
// Directed bench for bus_mux_stom_link with a short watchdog (TIMEOUT=4).
// Expected master line values are queued when slave data is driven and popped
// when the registered output appears one edge later.
module tb_bus_mux_stom_link;

    logic       clk;
    logic       rst;
    logic [0:0] master_sel;
    logic [1:0] slave_sel;
    logic       connect;
    logic       release_req;
    logic [2:0] slave;
    logic [1:0] master;
    logic       busy;
    logic       timeout;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    bus_mux_stom_link #(
        .NO_MASTERS(2),
        .NO_SLAVES (3),
        .TIMEOUT   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .master_sel (master_sel),
        .slave_sel  (slave_sel),
        .connect    (connect),
        .release_req(release_req),
        .slave      (slave),
        .master     (master),
        .busy       (busy),
        .timeout    (timeout),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive slave data, queue the master value due after the next edge, then compare
    task automatic drive_data(input string tag, input logic [2:0] s, input logic [1:0] e);
        logic [1:0] want;
        slave = s;
        exp_q.push_back(e);
        tick();
        want = exp_q.pop_front();
        check(tag, master, want);
    endtask

    task automatic do_connect(input logic m, input logic [1:0] s);
        master_sel = m;
        slave_sel  = s;
        connect    = 1'b1;
        tick();
        connect    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; master_sel = '0; slave_sel = '0; connect = 1'b0;
        release_req = 1'b0; slave = 3'b000;
        tick(); tick();
        rst = 1'b0;
        check("rst_master", master, 2'b11);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_err", err, 1'b0);

        // Connect m=1,s=2: busy next cycle, data one cycle later
        do_connect(1'b1, 2'd2);
        check("conn_busy", busy, 1'b1);
        check("conn_err", err, 1'b0);
        check("conn_first_idle", master, 2'b11);
        drive_data("d_s1_hi", 3'b010, 2'b11);
        drive_data("d_s1_lo", 3'b000, 2'b01);
        drive_data("d_s1_hi2", 3'b010, 2'b11);
        drive_data("d_other_slaves", 3'b101, 2'b01);

        // Async reset mid-link while master[1] drives 0
        rst = 1'b1;
        #2;
        check("async_master", master, 2'b11);
        check("async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        slave = 3'b000;

        // Invalid connects
        do_connect(1'b0, 2'd0);
        check("inv0_err", err, 1'b1);
        check("inv0_busy", busy, 1'b0);
        tick();
        check("inv0_pulse", err, 1'b0);
        do_connect(1'b1, 2'd0);
        check("inv1_err", err, 1'b1);
        check("inv1_busy", busy, 1'b0);
        tick();
        check("inv1_pulse", err, 1'b0);

        // Connect while busy is rejected and the link holds
        do_connect(1'b0, 2'd1);
        check("c01_busy", busy, 1'b1);
        check("c01_err", err, 1'b0);
        do_connect(1'b1, 2'd3);
        check("busy_conn_err", err, 1'b1);
        check("busy_conn_busy", busy, 1'b1);
        drive_data("hold_hi", 3'b001, 2'b11);
        drive_data("hold_lo", 3'b110, 2'b10);
        check("hold_err_clear", err, 1'b0);
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
        check("rel_busy", busy, 1'b0);
        check("rel_master", master, 2'b11);

        // Watchdog fires on the 4th idle cycle
        slave = 3'b010;
        do_connect(1'b1, 2'd2);
        tick(); check("wd_t1", timeout, 1'b0);
        tick(); check("wd_t2", timeout, 1'b0);
        tick(); check("wd_t3", timeout, 1'b0); check("wd_b3", busy, 1'b1);
        tick();
        check("wd_fire", timeout, 1'b1);
        check("wd_busy", busy, 1'b0);
        check("wd_master", master, 2'b11);
        tick();
        check("wd_pulse", timeout, 1'b0);

        // A non-idle bit on the 3rd cycle restarts the count
        do_connect(1'b1, 2'd2);
        drive_data("wr_1", 3'b010, 2'b11);
        drive_data("wr_2", 3'b010, 2'b11);
        drive_data("wr_3", 3'b000, 2'b01);
        drive_data("wr_4", 3'b010, 2'b11);
        drive_data("wr_5", 3'b010, 2'b11);
        drive_data("wr_6", 3'b010, 2'b11);
        check("wr_busy", busy, 1'b1);
        check("wr_no_to", timeout, 1'b0);
        tick();
        check("wr_fire", timeout, 1'b1);
        check("wr_fire_busy", busy, 1'b0);

        // Release beats connect while CONNECTED
        slave = 3'b000;
        do_connect(1'b0, 2'd1);
        check("rc_up", busy, 1'b1);
        master_sel = 1'b1; slave_sel = 2'd2; connect = 1'b1; release_req = 1'b1;
        tick();
        connect = 1'b0; release_req = 1'b0;
        check("rc_busy", busy, 1'b0);
        check("rc_err", err, 1'b0);
        check("rc_master", master, 2'b11);
        // In IDLE connect+release opens the link
        connect = 1'b1; release_req = 1'b1;
        tick();
        connect = 1'b0; release_req = 1'b0;
        check("ic_busy", busy, 1'b1);
        check("ic_err", err, 1'b0);
        drive_data("ic_data", 3'b000, 2'b01);

        // Back-to-back: release then connect m=0,s=3
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
        check("bb_rel", busy, 1'b0);
        check("bb_rel_master", master, 2'b11);
        do_connect(1'b0, 2'd3);
        check("bb_busy", busy, 1'b1);
        check("bb_first", master, 2'b11);
        drive_data("bb_hi", 3'b100, 2'b11);
        drive_data("bb_lo", 3'b000, 2'b10);
        drive_data("bb_lo2", 3'b011, 2'b10);
        drive_data("bb_hi2", 3'b111, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
